// File: rtl/spi_axi_slave_pkg.sv
// Shared definitions for the AXI4-lite to 3-wire SPI transmit bridge.
// Contents: default word/frame width, write-channel FSM state encoding and a
// helper that sizes the SPI bit counter.
package spi_axi_slave_pkg;

  // Default AXI data/address width and SPI frame length in bits.
  localparam int unsigned SWORD = 32;

  // Write-channel FSM: AW accept, W accept, serialise, write response.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWaitW = 2'd1,
    StShift = 2'd2,
    StResp  = 2'd3
  } wr_state_e;

  // Bit counter width: one spare bit above clog2 of the frame length.
  function automatic int unsigned bit_cnt_w(input int unsigned sword);
    return $clog2(sword) + 1;
  endfunction

endpackage

// File: rtl/spi_axi_slave_bridge_spi_tx_shifter.sv
// spi_tx_shifter: loads one word and serialises it MSB first on a 3-wire SPI
// link. Each bit takes two clocks: SCLK low then SCLK high, DATA stable across
// both. CEB is low for the whole frame; DATA and SCLK idle low.
// Ports:
//   clk_i   system clock
//   rst_i   synchronous active-high reset, aborts any frame in progress
//   load_i  load word_i and start a frame on the next edge
//   word_i  word to transmit
//   sclk_o  SPI clock
//   ceb_o   active-low frame enable
//   data_o  serial data
//   done_o  high during the last clock of a frame (the SCLK-high half of bit 0)
module spi_tx_shifter #(
  parameter int unsigned SWORD = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [SWORD-1:0] word_i,
  output logic             sclk_o,
  output logic             ceb_o,
  output logic             data_o,
  output logic             done_o
);
  import spi_axi_slave_pkg::*;

  localparam int unsigned CntW = bit_cnt_w(SWORD);

  logic             busy_q;
  logic             sclk_q;
  logic [SWORD-1:0] shreg_q;
  logic [CntW-1:0]  cnt_q;
  logic             last_bit;

  assign last_bit = (cnt_q == CntW'(SWORD - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q  <= 1'b0;
      sclk_q  <= 1'b0;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (load_i) begin
      busy_q  <= 1'b1;
      sclk_q  <= 1'b0;
      shreg_q <= word_i;
      cnt_q   <= '0;
    end else if (busy_q) begin
      if (!sclk_q) begin
        sclk_q <= 1'b1;
      end else if (last_bit) begin
        busy_q  <= 1'b0;
        sclk_q  <= 1'b0;
        shreg_q <= '0;
      end else begin
        // Falling SCLK: advance to the next bit.
        sclk_q  <= 1'b0;
        shreg_q <= shreg_q << 1;
        cnt_q   <= cnt_q + CntW'(1);
      end
    end
  end

  // Outputs are decoded from registered state only.
  assign sclk_o = sclk_q;
  assign ceb_o  = ~busy_q;
  assign data_o = busy_q & shreg_q[SWORD-1];
  assign done_o = busy_q & sclk_q & last_bit;

endmodule

// File: rtl/spi_axi_slave_bridge.sv
// spi_axi_slave_bridge: AXI4-lite slave whose single write register is sent
// out as one SPI frame; the write response is issued once the frame is done.
// Optional feature macro: SPI_AXI_SLAVE_READBACK_EN enables a read channel
// returning the last fully transmitted word. Without it, arready is tied high,
// rvalid pulses one cycle after each arvalid and rdata is zero.
// Ports:
//   CLK, RST             clock, synchronous active-high reset
//   axi_aw*, axi_w*      write address / data channels (address, prot, strobes
//                        ignored; the full word is always sent)
//   axi_bvalid/bready    write response, always OKAY
//   axi_ar*, axi_r*      read address / data channels
//   SCLK, CEB, DATA      3-wire transmit-only SPI link
module spi_axi_slave_bridge #(
  parameter int unsigned SWORD = spi_axi_slave_pkg::SWORD
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             axi_awvalid,
  output logic             axi_awready,
  input  logic [SWORD-1:0] axi_awaddr,
  input  logic [2:0]       axi_awprot,
  input  logic             axi_wvalid,
  output logic             axi_wready,
  input  logic [SWORD-1:0] axi_wdata,
  input  logic [3:0]       axi_wstrb,
  output logic             axi_bvalid,
  input  logic             axi_bready,
  input  logic             axi_arvalid,
  output logic             axi_arready,
  input  logic [SWORD-1:0] axi_araddr,
  input  logic [2:0]       axi_arprot,
  output logic             axi_rvalid,
  input  logic             axi_rready,
  output logic [SWORD-1:0] axi_rdata,
  output logic             SCLK,
  output logic             CEB,
  output logic             DATA
);
  import spi_axi_slave_pkg::*;

  wr_state_e state_q;
  logic      awready_q;
  logic      wready_q;
  logic      bvalid_q;
  logic      tx_load;
  logic      tx_done;

  assign tx_load = (state_q == StWaitW) && wready_q && axi_wvalid;

  // Write FSM with registered handshake outputs. AW and W are taken strictly
  // one after the other, so awready never looks at wvalid.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (awready_q && axi_awvalid) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            state_q   <= StWaitW;
          end else begin
            awready_q <= 1'b1;
          end
        end
        StWaitW: begin
          if (tx_load) begin
            wready_q <= 1'b0;
            state_q  <= StShift;
          end
        end
        StShift: begin
          if (tx_done) begin
            bvalid_q <= 1'b1;
            state_q  <= StResp;
          end
        end
        StResp: begin
          if (axi_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign axi_awready = awready_q;
  assign axi_wready  = wready_q;
  assign axi_bvalid  = bvalid_q;

  spi_tx_shifter #(
    .SWORD (SWORD)
  ) u_tx (
    .clk_i  (CLK),
    .rst_i  (RST),
    .load_i (tx_load),
    .word_i (axi_wdata),
    .sclk_o (SCLK),
    .ceb_o  (CEB),
    .data_o (DATA),
    .done_o (tx_done)
  );

`ifdef SPI_AXI_SLAVE_READBACK_EN
  logic [SWORD-1:0] pend_q;
  logic [SWORD-1:0] last_q;
  logic [SWORD-1:0] rdata_q;
  logic             arready_q;
  logic             rvalid_q;

  // pend_q holds the word in flight; it only becomes readable once the frame
  // completes, so an aborted frame never reaches last_q.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_q    <= '0;
      last_q    <= '0;
      rdata_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      if (tx_load) begin
        pend_q <= axi_wdata;
      end
      if (tx_done) begin
        last_q <= pend_q;
      end
      if (rvalid_q) begin
        if (axi_rready) begin
          rvalid_q  <= 1'b0;
          arready_q <= 1'b1;
        end
      end else if (arready_q && axi_arvalid) begin
        rvalid_q  <= 1'b1;
        arready_q <= 1'b0;
        rdata_q   <= last_q;
      end else begin
        arready_q <= 1'b1;
      end
    end
  end

  assign axi_arready = arready_q;
  assign axi_rvalid  = rvalid_q;
  assign axi_rdata   = rdata_q;

  logic unused_in;
  assign unused_in = ^{axi_awaddr, axi_awprot, axi_wstrb, axi_araddr, axi_arprot};
`else
  logic rvalid_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= axi_arvalid;
    end
  end

  assign axi_arready = 1'b1;
  assign axi_rvalid  = rvalid_q;
  assign axi_rdata   = '0;

  logic unused_in;
  assign unused_in = ^{axi_awaddr, axi_awprot, axi_wstrb, axi_araddr, axi_arprot, axi_rready};
`endif

endmodule

// File: tb/tb_spi_axi_slave_bridge.sv
module tb_spi_axi_slave_bridge;

  logic        CLK = 1'b0;
  logic        RST;
  logic        axi_awvalid, axi_awready;
  logic [31:0] axi_awaddr;
  logic [2:0]  axi_awprot;
  logic        axi_wvalid, axi_wready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_bvalid, axi_bready;
  logic        axi_arvalid, axi_arready;
  logic [31:0] axi_araddr;
  logic [2:0]  axi_arprot;
  logic        axi_rvalid, axi_rready;
  logic [31:0] axi_rdata;
  logic        SCLK, CEB, DATA;

  spi_axi_slave_bridge #(
    .SWORD (32)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .axi_awvalid (axi_awvalid),
    .axi_awready (axi_awready),
    .axi_awaddr  (axi_awaddr),
    .axi_awprot  (axi_awprot),
    .axi_wvalid  (axi_wvalid),
    .axi_wready  (axi_wready),
    .axi_wdata   (axi_wdata),
    .axi_wstrb   (axi_wstrb),
    .axi_bvalid  (axi_bvalid),
    .axi_bready  (axi_bready),
    .axi_arvalid (axi_arvalid),
    .axi_arready (axi_arready),
    .axi_araddr  (axi_araddr),
    .axi_arprot  (axi_arprot),
    .axi_rvalid  (axi_rvalid),
    .axi_rready  (axi_rready),
    .axi_rdata   (axi_rdata),
    .SCLK        (SCLK),
    .CEB         (CEB),
    .DATA        (DATA)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] cap_word;
  int          cap_cnt;

  // SPI receiver model: sample DATA on SCLK rising edges while CEB is low.
  always @(posedge SCLK) begin
    if (!CEB) begin
      cap_word = {cap_word[30:0], DATA};
      cap_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Runs AW then W handshakes; returns at the negedge just after the W handshake.
  task automatic start_write(input logic [31:0] d, input bit simul);
    int n;
    cap_cnt  = 0;
    cap_word = '0;
    axi_awvalid = 1'b1;
    if (simul) begin
      axi_wvalid = 1'b1;
      axi_wdata  = d;
    end
    n = 0;
    while (!axi_awready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("aw_timeout", 32'(n >= 50), 0);
    if (simul) chk("w_held_off_in_idle", axi_wready, 0);
    @(negedge CLK);
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b1;
    axi_wdata   = d;
    chk("wready_after_aw", axi_wready, 1);
    chk("awready_low_in_wait_w", axi_awready, 0);
    n = 0;
    while (!axi_wready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    @(negedge CLK);
    axi_wvalid = 1'b0;
    chk("ceb_fall_after_w", CEB, 0);
  endtask

  // Waits for bvalid, checks the captured frame, completes the B handshake.
  task automatic finish_write(input logic [31:0] exp_word, input int exp_edges,
                              input int exp_lat, input int bdelay);
    int k;
    k = 1;
    while (!axi_bvalid && k < 200) begin
      @(negedge CLK);
      k++;
    end
    chk("bvalid_latency", k, exp_lat);
    chk("ceb_rise_with_bvalid", CEB, 1);
    chk("sclk_idle_after_frame", SCLK, 0);
    chk("data_idle_after_frame", DATA, 0);
    chk("sclk_edges", cap_cnt, exp_edges);
    chk("captured_word", cap_word, exp_word);
    for (int i = 0; i < bdelay; i++) begin
      @(negedge CLK);
      chk("bvalid_held", axi_bvalid, 1);
    end
    axi_bready = 1'b1;
    @(negedge CLK);
    axi_bready = 1'b0;
    chk("bvalid_cleared", axi_bvalid, 0);
    chk("awready_after_b", axi_awready, 1);
    chk("ceb_high_after_b", CEB, 1);
  endtask

  task automatic do_read(input logic [31:0] exp);
`ifdef SPI_AXI_SLAVE_READBACK_EN
    int n;
    axi_arvalid = 1'b1;
    n = 0;
    while (!axi_arready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("ar_timeout", 32'(n >= 20), 0);
    @(negedge CLK);
    axi_arvalid = 1'b0;
    chk("rvalid_set", axi_rvalid, 1);
    chk("rdata", axi_rdata, exp);
    @(negedge CLK);
    chk("rvalid_held", axi_rvalid, 1);
    chk("arready_low_while_rvalid", axi_arready, 0);
    axi_rready = 1'b1;
    @(negedge CLK);
    axi_rready = 1'b0;
    chk("rvalid_cleared", axi_rvalid, 0);
`else
    axi_arvalid = 1'b1;
    @(negedge CLK);
    axi_arvalid = 1'b0;
    chk("rvalid_pulse", axi_rvalid, 1);
    chk("rdata_zero", axi_rdata, exp);
    @(negedge CLK);
    chk("rvalid_pulse_end", axi_rvalid, 0);
`endif
  endtask

  typedef struct {
    logic [31:0] wdata;
    bit          simul;
    int          bdelay;
    logic [31:0] exp_word;
    int          exp_edges;
    int          exp_lat;
  } vec_t;

  vec_t        vecs[5];
  logic [63:0] xs;
  logic [31:0] rd_exp;

  initial begin
    vecs[0] = '{32'hA5A50F0F, 1'b0, 0,  32'hA5A50F0F, 32, 65};
    vecs[1] = '{32'h0000FFFF, 1'b1, 0,  32'h0000FFFF, 32, 65};
    vecs[2] = '{32'h3C3CC3C3, 1'b0, 10, 32'h3C3CC3C3, 32, 65};
    vecs[3] = '{32'h00000000, 1'b0, 2,  32'h00000000, 32, 65};
    vecs[4] = '{32'hFFFFFFFF, 1'b0, 1,  32'hFFFFFFFF, 32, 65};

    RST = 1'b1;
    axi_awvalid = 0; axi_awaddr = 0; axi_awprot = 0;
    axi_wvalid = 0;  axi_wdata = 0;  axi_wstrb = 4'hF;
    axi_bready = 0;  axi_arvalid = 0; axi_araddr = 0; axi_arprot = 0;
    axi_rready = 0;
    cap_word = '0;
    cap_cnt = 0;
    repeat (3) @(negedge CLK);

    chk("rst_awready", axi_awready, 0);
    chk("rst_wready", axi_wready, 0);
    chk("rst_bvalid", axi_bvalid, 0);
    chk("rst_rvalid", axi_rvalid, 0);
    chk("rst_rdata", axi_rdata, 0);
    chk("rst_sclk", SCLK, 0);
    chk("rst_ceb", CEB, 1);
    chk("rst_data", DATA, 0);
`ifdef SPI_AXI_SLAVE_READBACK_EN
    chk("rst_arready", axi_arready, 0);
`else
    chk("rst_arready", axi_arready, 1);
`endif
    RST = 1'b0;
    @(negedge CLK);
    chk("awready_after_rst", axi_awready, 1);

    do_read(32'h0);

    for (int i = 0; i < 5; i++) begin
      start_write(vecs[i].wdata, vecs[i].simul);
      finish_write(vecs[i].exp_word, vecs[i].exp_edges, vecs[i].exp_lat, vecs[i].bdelay);
    end

    start_write(32'h80000001, 1'b0);
    finish_write(32'h80000001, 32, 65, 0);
`ifdef SPI_AXI_SLAVE_READBACK_EN
    rd_exp = 32'h80000001;
`else
    rd_exp = 32'h0;
`endif
    do_read(rd_exp);

    // Abort a frame with reset after ten bits have been clocked.
    start_write(32'hFFFFFFFF, 1'b0);
    repeat (20) @(negedge CLK);
    chk("edges_before_abort", cap_cnt, 10);
    RST = 1'b1;
    @(negedge CLK);
    chk("abort_ceb", CEB, 1);
    chk("abort_sclk", SCLK, 0);
    chk("abort_data", DATA, 0);
    chk("abort_bvalid", axi_bvalid, 0);
    RST = 1'b0;
    @(negedge CLK);
    chk("awready_after_abort", axi_awready, 1);
    start_write(32'h12345678, 1'b0);
    finish_write(32'h12345678, 32, 65, 0);
`ifdef SPI_AXI_SLAVE_READBACK_EN
    do_read(32'h12345678);
`endif

    xs = 64'd88172645463325252;
    for (int i = 0; i < 512; i++) begin
      xs = xs ^ (xs << 13);
      xs = xs ^ (xs >> 7);
      xs = xs ^ (xs << 17);
      start_write(xs[31:0], 1'b0);
      finish_write(xs[31:0], 32, 65, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
